// File: rtl/char_fetch_sequencer.sv
// Text-mode character fetch sequencer: a nine-cycle cell schedule that fetches a VRAM word and a font byte, then hands the cell to the pixel generator.
// The spare VRAM slot in each cell goes to the CPU. Optional cursor compare logic is included when CURSOR_EN is defined.
module char_fetch_sequencer #(
  parameter int COLS   = 80,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [3:0]        scanline,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  output logic              vram_we,
  output logic [15:0]       vram_wdata,
  input  logic [15:0]       vram_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_q,
  output logic              load,
  output logic [7:0]        attribute_data,
  output logic [7:0]        font_data,
  output logic [2:0]        char_msbs,
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic [3:0]        cursor_start,
  input  logic [3:0]        cursor_end,
  input  logic              cursor_blink,
  output logic              cursor_active,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic              busy
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  state_t            state, state_next;
  logic [3:0]        phase, phase_next;
  logic [7:0]        col, col_next;
  logic [ADDR_W-1:0] fetch_addr;
  logic              grant;
  logic              load_now;
  logic              idle_grant;
  logic              ack_pending;
  logic              ack_we;
  logic [7:0]        char_stage;
  logic [7:0]        attr_stage;
  logic [7:0]        font_stage;

  assign fetch_addr = row_base + ADDR_W'(col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      phase <= 4'd0;
      col   <= 8'd0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      col   <= col_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    col_next   = col;
    grant      = 1'b0;
    load_now   = 1'b0;
    vram_addr  = '0;
    vram_rd    = 1'b0;
    vram_we    = 1'b0;
    vram_wdata = 16'd0;
    font_addr  = 12'd0;
    case (state)
      IDLE: begin
        grant = idle_grant;
        if (line_start) begin
          state_next = FETCH;
          phase_next = 4'd0;
          col_next   = 8'd0;
        end
      end
      FETCH: begin
        if (line_start) begin
          // Restart: the CPU slot of this cycle (if any) is not granted.
          phase_next = 4'd0;
          col_next   = 8'd0;
        end else begin
          if (phase == 4'd8) begin
            phase_next = 4'd0;
            if (col == LAST_COL) begin
              state_next = IDLE;
              col_next   = 8'd0;
            end else begin
              col_next = col + 8'd1;
            end
          end else begin
            phase_next = phase + 4'd1;
          end
          grant    = (phase == 4'd4) && cpu_req;
          load_now = (phase == 4'd7);
        end
        if (phase == 4'd0) begin
          vram_addr = fetch_addr;
          vram_rd   = 1'b1;
        end
        if (phase == 4'd2) begin
          font_addr = {char_stage, scanline};
        end
      end
      default: ;
    endcase
    if (grant) begin
      vram_addr  = cpu_addr;
      vram_rd    = ~cpu_we;
      vram_we    = cpu_we;
      vram_wdata = cpu_we ? cpu_wdata : 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_grant     <= 1'b0;
      ack_pending    <= 1'b0;
      ack_we         <= 1'b0;
      char_stage     <= 8'd0;
      attr_stage     <= 8'd0;
      font_stage     <= 8'd0;
      load           <= 1'b0;
      attribute_data <= 8'd0;
      font_data      <= 8'd0;
      char_msbs      <= 3'd0;
    end else begin
      // The CPU still holds cpu_req during grant and ack cycles; do not re-grant it.
      idle_grant  <= (state_next == IDLE) && cpu_req && !grant && !ack_pending;
      ack_pending <= grant;
      if (grant) begin
        ack_we <= cpu_we;
      end
      if (state == FETCH && phase == 4'd1) begin
        char_stage <= vram_data[7:0];
        attr_stage <= vram_data[15:8];
      end
      if (state == FETCH && phase == 4'd3) begin
        font_stage <= font_q;
      end
      load <= load_now;
      if (load_now) begin
        attribute_data <= attr_stage;
        font_data      <= font_stage;
        char_msbs      <= char_stage[7:5];
      end
    end
  end

  assign cpu_ack   = ack_pending;
  assign cpu_rdata = (ack_pending && !ack_we) ? vram_data : 16'd0;
  assign busy      = (state == FETCH);

`ifdef CURSOR_EN
  logic cursor_hit;
  logic cursor_stage;

  assign cursor_hit = (fetch_addr == cursor_addr) && (cursor_start <= scanline) &&
                      (scanline <= cursor_end) && cursor_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_stage  <= 1'b0;
      cursor_active <= 1'b0;
    end else begin
      if (state == FETCH && phase == 4'd1) begin
        cursor_stage <= cursor_hit;
      end
      if (load_now) begin
        cursor_active <= cursor_stage;
      end
    end
  end
`else
  logic cursor_unused;
  assign cursor_unused = ^{cursor_addr, cursor_start, cursor_end, cursor_blink};
  assign cursor_active = 1'b0;
`endif

endmodule

// File: tb/tb_char_fetch_sequencer.sv
// Bench for char_fetch_sequencer: a cycle-count model checks the fetch outputs on every cycle.
// Directed runs also pin load timing, the data path, CPU slots, restart and reset with hand-computed literals.
`timescale 1ns/1ps
module tb_char_fetch_sequencer;
  localparam int COLS   = 4;
  localparam int ADDR_W = 11;
  localparam int CELL   = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              line_start = 1'b0;
  logic [ADDR_W-1:0] row_base = '0;
  logic [3:0]        scanline = '0;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_rd, vram_we;
  logic [15:0]       vram_wdata;
  logic [15:0]       vram_data = '0;
  logic [11:0]       font_addr;
  logic [7:0]        font_q = '0;
  logic              load;
  logic [7:0]        attribute_data, font_data;
  logic [2:0]        char_msbs;
  logic [ADDR_W-1:0] cursor_addr = 11'h7FF;
  logic [3:0]        cursor_start = 4'd0, cursor_end = 4'd0;
  logic              cursor_blink = 1'b0;
  logic              cursor_active;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [15:0]       cpu_wdata = '0;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;
  logic              busy;

  int checks = 0;
  int failures = 0;

  char_fetch_sequencer #(.COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .row_base(row_base),
    .scanline(scanline), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_data(vram_data), .font_addr(font_addr), .font_q(font_q),
    .load(load), .attribute_data(attribute_data), .font_data(font_data),
    .char_msbs(char_msbs), .cursor_addr(cursor_addr), .cursor_start(cursor_start),
    .cursor_end(cursor_end), .cursor_blink(cursor_blink), .cursor_active(cursor_active),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the sequencer.
  function automatic logic [15:0] vram_fn(input logic [ADDR_W-1:0] a);
    case (a)
      11'h101: return 16'h1EC4;
      11'h010: return 16'h1234;
      default: return {a[7:0] ^ 8'h5A, a[7:0] + 8'h31};
    endcase
  endfunction

  function automatic logic [7:0] font_fn(input logic [11:0] a);
    if (a == 12'hC45) return 8'hA5;
    return a[7:0] ^ {a[3:0], a[11:8]};
  endfunction

  always @(posedge clk) begin
    if (vram_rd) vram_data <= vram_fn(vram_addr);
    font_q <= font_fn(font_addr);
  end

  // Model: m_t counts cycles since the line started (1 = phase 0 of column 0).
  int          m_t = 0;
  logic [15:0] exp_word;
  logic [7:0]  exp_fontb;
  logic        exp_cur;

  function automatic int next_t(input logic ls, input int t);
    if (ls) return 1;
    if (t != 0 && t < CELL * COLS) return t + 1;
    return 0;
  endfunction

  function automatic logic is_load_t(input int t);
    return (t != 0) && ((t - 1) % CELL == CELL - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input int t);
    return row_base + ADDR_W'((t - 1) / CELL);
  endfunction

  function automatic logic [7:0] font_of(input logic [15:0] w);
    return font_fn({w[7:0], scanline});
  endfunction

  function automatic logic cursor_model(input logic [ADDR_W-1:0] a);
`ifdef CURSOR_EN
    return (a == cursor_addr) && (cursor_start <= scanline) && (scanline <= cursor_end) && cursor_blink;
`else
    return (a != a);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t       <= 0;
      exp_word  <= 16'd0;
      exp_fontb <= 8'd0;
      exp_cur   <= 1'b0;
    end else begin
      m_t <= next_t(line_start, m_t);
      if (is_load_t(next_t(line_start, m_t))) begin
        exp_word  <= vram_fn(cell_addr(next_t(line_start, m_t)));
        exp_fontb <= font_of(vram_fn(cell_addr(next_t(line_start, m_t))));
        exp_cur   <= cursor_model(cell_addr(next_t(line_start, m_t)));
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_t != 0);
    check("load", load, is_load_t(m_t));
    check("attribute_data", attribute_data, exp_word[15:8]);
    check("font_data", font_data, exp_fontb);
    check("char_msbs", char_msbs, exp_word[7:5]);
    check("cursor_active", cursor_active, exp_cur);
    check("rd_we_exclusive", vram_rd & vram_we, 0);
    if (m_t != 0 && (m_t - 1) % CELL == 0) begin
      check("fetch_addr", vram_addr, cell_addr(m_t));
      check("fetch_rd", vram_rd, 1);
      check("fetch_we", vram_we, 0);
    end else if (m_t != 0 && (m_t - 1) % CELL != 4) begin
      check("vram_quiet", vram_rd | vram_we, 0);
    end
  end

  // Per-run records for the literal checks.
  logic [ADDR_W-1:0] cyc_addr [0:79];
  logic              cyc_rd   [0:79];
  logic              cyc_we   [0:79];
  logic              cyc_busy [0:79];
  logic              cyc_load [0:79];
  logic              cyc_ack  [0:79];
  logic [11:0]       cyc_fa   [0:79];
  int                ld_cyc   [0:7];
  logic [7:0]        ld_attr  [0:7];
  logic [7:0]        ld_font  [0:7];
  logic [2:0]        ld_msbs  [0:7];
  logic              ld_cur   [0:7];
  int                n_loads, grant_cyc, ack_cyc, n_acks;
  logic              grant_we;
  logic [15:0]       grant_wdata, ack_data;

  task automatic run(input string name, input logic do_start, input logic [ADDR_W-1:0] base,
                     input logic [3:0] sl, input int req_cyc, input logic we,
                     input logic [ADDR_W-1:0] addr, input logic [15:0] wd,
                     input int restart_cyc, input int reset_cyc, input int ncyc);
    row_base = base;
    scanline = sl;
    n_loads = 0; grant_cyc = 0; ack_cyc = 0; n_acks = 0;
    grant_we = 1'b0; grant_wdata = 16'd0; ack_data = 16'd0;
    if (do_start) begin
      line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
    end
    for (int n = 1; n <= ncyc; n++) begin
      line_start = (n == restart_cyc);
      reset = (reset_cyc != 0) && (n >= reset_cyc) && (n < reset_cyc + 2);
      if (n == req_cyc) begin
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      end
      if (reset) cpu_req = 1'b0;
      @(negedge clk);
      cyc_addr[n] = vram_addr; cyc_rd[n] = vram_rd; cyc_we[n] = vram_we;
      cyc_busy[n] = busy; cyc_load[n] = load; cyc_ack[n] = cpu_ack; cyc_fa[n] = font_addr;
      if (load && n_loads < 8) begin
        ld_cyc[n_loads] = n; ld_attr[n_loads] = attribute_data; ld_font[n_loads] = font_data;
        ld_msbs[n_loads] = char_msbs; ld_cur[n_loads] = cursor_active;
        n_loads++;
      end
      if (cpu_req && (vram_rd || vram_we) && vram_addr == cpu_addr && grant_cyc == 0) begin
        grant_cyc = n; grant_we = vram_we; grant_wdata = vram_wdata;
      end
      if (cpu_ack) begin
        n_acks++;
        if (ack_cyc == 0) ack_cyc = n;
        ack_data = cpu_rdata;
      end
      @(posedge clk); #1;
      if (cyc_ack[n]) cpu_req = 1'b0;
    end
    line_start = 1'b0;
    reset = 1'b0;
    cpu_req = 1'b0;
    $display("txn %s loads=%0d grant_cycle=%0d ack_cycle=%0d acks=%0d rdata=0x%0h",
             name, n_loads, grant_cyc, ack_cyc, n_acks, ack_data);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_vram_addr", vram_addr, 0);
    check("reset_vram_rd", vram_rd, 0);
    check("reset_font_addr", font_addr, 0);
    check("reset_cpu_ack", cpu_ack, 0);
    check("reset_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;

    // Single line plus data path.
    run("single_line", 1'b1, 11'h100, 4'd5, 0, 1'b0, '0, '0, 0, 0, 40);
    check("sl_load_count", n_loads, 4);
    for (int k = 0; k < 4; k++) begin
      check("sl_load_cycle", ld_cyc[k], 9 * (k + 1));
      check("sl_fetch_addr", cyc_addr[9 * k + 1], 11'h100 + k);
      check("sl_fetch_rd", cyc_rd[9 * k + 1], 1);
    end
    check("sl_load_one_cycle", cyc_load[10], 0);
    check("sl_busy_36", cyc_busy[36], 1);
    check("sl_busy_37", cyc_busy[37], 0);
    check("dp_font_addr", cyc_fa[12], 12'hC45);
    check("dp_attr", ld_attr[1], 8'h1E);
    check("dp_font", ld_font[1], 8'hA5);
    check("dp_msbs", ld_msbs[1], 3'b110);
    check("sl_no_ack", n_acks, 0);

    // CPU write raised in phase 6 of column 0.
    run("cpu_write_line", 1'b1, 11'h100, 4'd5, 7, 1'b1, 11'h200, 16'hBEEF, 0, 0, 40);
    check("wr_grant_cycle", grant_cyc, 14);
    check("wr_grant_we", grant_we, 1);
    check("wr_grant_rd", cyc_rd[14], 0);
    check("wr_wdata", grant_wdata, 16'hBEEF);
    check("wr_ack_cycle", ack_cyc, 15);
    check("wr_ack_count", n_acks, 1);
    check("wr_load_count", n_loads, 4);
    check("wr_last_load", ld_cyc[3], 36);

    // CPU read while idle.
    run("cpu_read_idle", 1'b0, 11'h100, 4'd5, 1, 1'b0, 11'h010, 16'h0, 0, 0, 6);
    check("rd_grant_cycle", grant_cyc, 2);
    check("rd_vram_rd", cyc_rd[2], 1);
    check("rd_vram_we", cyc_we[2], 0);
    check("rd_ack_cycle", ack_cyc, 3);
    check("rd_rdata", ack_data, 16'h1234);
    check("rd_ack_count", n_acks, 1);

    // Cursor on the third cell only when scanline is in range and blink is on.
    cursor_addr = 11'h102; cursor_start = 4'd13; cursor_end = 4'd14; cursor_blink = 1'b1;
    run("cursor_on", 1'b1, 11'h100, 4'd13, 0, 1'b0, '0, '0, 0, 0, 40);
    for (int k = 0; k < 4; k++) begin
`ifdef CURSOR_EN
      check("cur_on", ld_cur[k], k == 2);
`else
      check("cur_on", ld_cur[k], 0);
`endif
    end
    run("cursor_scan12", 1'b1, 11'h100, 4'd12, 0, 1'b0, '0, '0, 0, 0, 40);
    for (int k = 0; k < 4; k++) check("cur_scan12", ld_cur[k], 0);
    cursor_blink = 1'b0;
    run("cursor_noblink", 1'b1, 11'h100, 4'd13, 0, 1'b0, '0, '0, 0, 0, 40);
    for (int k = 0; k < 4; k++) check("cur_noblink", ld_cur[k], 0);
    cursor_addr = 11'h7FF;

    // Restart at column 2, phase 4 with a read pending.
    run("restart", 1'b1, 11'h100, 4'd5, 20, 1'b0, 11'h300, 16'h0, 23, 0, 64);
    check("rs_no_grant_23", (cyc_rd[23] || cyc_we[23]) && cyc_addr[23] == 11'h300, 0);
    check("rs_no_ack_24", cyc_ack[24], 0);
    check("rs_col0_addr", cyc_addr[24], 11'h100);
    check("rs_grant_cycle", grant_cyc, 28);
    check("rs_ack_cycle", ack_cyc, 29);
    check("rs_ack_count", n_acks, 1);
    check("rs_load_count", n_loads, 6);
    check("rs_restart_load", ld_cyc[2], 32);
    check("rs_last_load", ld_cyc[5], 59);

    // Reset in the ack cycle of a mid-line CPU read.
    run("reset_mid", 1'b1, 11'h100, 4'd5, 13, 1'b0, 11'h300, 16'h0, 0, 15, 30);
    check("rm_grant_cycle", grant_cyc, 14);
    check("rm_ack_count", n_acks, 0);
    check("rm_load_count", n_loads, 1);
    check("rm_busy_15", cyc_busy[15], 0);
    check("rm_no_load_18", cyc_load[18], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_fetch_sequencer.md
# char_fetch_sequencer

Sequences the text-mode character pipeline for one scanline. For each 9-pixel character cell it reads the character/attribute word from VRAM, then the font byte from the font ROM. It then presents font, attribute, character MSBs and cursor state to the pixel generator with a glitch-free registered `load` pulse. The one spare VRAM slot in each cell is given to the host CPU through a req/ack handshake, so display fetch and CPU access share the single-port VRAM without contention.

## Interface
- `COLS`, 80: character cells fetched per scanline (1..255).
- `ADDR_W`, 11: VRAM word address width.
- `clk`  input  1  pixel clock.
- `reset`  input  1  asynchronous, active-high reset.
- `line_start`  input  1  one-cycle pulse; starts fetch of a visible scanline.
- `row_base`  input  ADDR_W  VRAM address of column 0 of the current text row; stable from `line_start` to end of line.
- `scanline`  input  4  scanline within the character row (0..15).
- `vram_addr`  output  ADDR_W  VRAM address.
- `vram_rd`  output  1  VRAM read strobe.
- `vram_we`  output  1  VRAM write strobe.
- `vram_wdata`  output  16  VRAM write data.
- `vram_data`  input  16  {attr[15:8], char[7:0]}, synchronous, valid the cycle after `vram_rd`.
- `font_addr`  output  12  {char, scanline}.
- `font_q`  input  8  font ROM data, synchronous, valid the cycle after `font_addr`.
- `load`  output  1  registered load strobe to the pixel generator.
- `attribute_data`  output  8  latched attribute.
- `font_data`  output  8  latched font byte.
- `char_msbs`  output  3  char[7:5] of the latched character.
- `cursor_addr`  input  ADDR_W  cursor VRAM address.
- `cursor_start`, `cursor_end`  input  4 each  first/last cursor scanline, inclusive.
- `cursor_blink`  input  1  cursor visible phase.
- `cursor_active`  output  1  cursor drawn on this cell.
- `cpu_req`  input  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  input  1  1 = write, 0 = read.
- `cpu_addr`  input  ADDR_W  CPU address.
- `cpu_wdata`  input  16  CPU write data.
- `cpu_ack`  output  1  one-cycle completion pulse.
- `cpu_rdata`  output  16  read data, valid while `cpu_ack` is high.
- `busy`  output  1  high while in FETCH.

## Operation
- States are IDLE and FETCH.
  - FETCH holds a 4-bit `phase` counter (0..8) and an 8-bit `col` counter (0..COLS-1).
  - Leaving reset, or on return to IDLE, `phase` = 0 and `col` = 0.
- IDLE → FETCH on `line_start`.
  - `line_start` during FETCH restarts the line: `col` = 0, `phase` = 0, and any pending CPU slot is abandoned without ack.
- Per-cell phases:
  - 0: `vram_addr` = `row_base` + `col`, `vram_rd` = 1. The sum is truncated to ADDR_W bits, so addresses wrap modulo 2^ADDR_W.
  - 1: capture `vram_data` into the char/attr staging registers. The cursor hit is computed as fetch address == `cursor_addr` and `cursor_start` ≤ `scanline` ≤ `cursor_end` and `cursor_blink`; it is false when `cursor_start` > `cursor_end`.
  - 2: `font_addr` = {char, `scanline`}.
  - 3: capture `font_q`.
  - 4: CPU slot. If `cpu_req` is high, drive `vram_addr` = `cpu_addr`, `vram_rd` = ~`cpu_we`, `vram_we` = `cpu_we`, `vram_wdata` = `cpu_wdata`.
  - 5: if a slot was granted in phase 4, `cpu_ack` = 1; for a read, `cpu_rdata` = `vram_data`.
  - 6, 7: no VRAM activity.
  - 8: transfer staging to the output registers (`attribute_data`, `font_data`, `char_msbs`, `cursor_active`) and hold `load` = 1 for this cycle.
- Phase 8 wraps to 0 and `col` increments. At phase 8 with `col` = COLS-1, go to IDLE.
- In IDLE, a pending `cpu_req` is granted on the next cycle and acked the cycle after, so IDLE gives 2-cycle latency. At most one access is in flight.
- `cpu_req` arriving in phases 5..8 or 0..3 waits for the next phase 4, or for IDLE.
- Output registers hold their values between loads.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-line aborts with no further `load` and no `cpu_ack`.

## Timing
- `line_start` sampled high at edge E0 means phase 0 is the cycle after E0.
- The first `load` is high during cycle 9 after E0. The pixel generator shifts the first pixel on the edge that ends that cycle.
- Successive `load` pulses are exactly 9 cycles apart; a line has exactly COLS pulses.
- `busy` falls on the edge after the last phase 8.
- `load` is driven directly from a flop, never from combinational logic.
- `vram_rd` and `vram_we` are never both high. CPU and fetch never drive VRAM in the same cycle.
- Worst-case CPU latency during a line is 10 cycles, req to ack.

## Configuration
- `CURSOR_EN` defined: cursor compare logic is present as described.
- `CURSOR_EN` undefined: `cursor_active` is constant 0, the cursor inputs are ignored, and no compare logic is synthesised.

## Test plan
- **Single line:** COLS=4, `row_base`=0x100, `line_start` pulse → `vram_addr` 0x100..0x103 at phases 0; four `load` pulses at cycles 9, 18, 27, 36 after E0; `busy` low at cycle 37.
- **Data path:** VRAM word 0x1EC4 at 0x101, `scanline`=5, font[0xC45]=0xA5 → second load shows `attribute_data`=0x1E, `font_data`=0xA5, `char_msbs`=3'b110, `font_addr`=0xC45 at that cell's phase 2.
- **CPU write during line:** `cpu_req`/`cpu_we`=1 with addr 0x200, data 0xBEEF asserted at phase 6 → `vram_we` high at the next phase 4 with addr 0x200; `cpu_ack` at phase 5; `load` timing unchanged.
- **CPU read in IDLE:** read of 0x010 holding 0x1234 → `vram_rd` the next cycle, `cpu_ack` with `cpu_rdata`=0x1234 one cycle later.
- **Cursor** (`CURSOR_EN` defined): `cursor_addr`=0x102, start=13, end=14, `scanline`=13, `cursor_blink`=1 → `cursor_active`=1 only at the third load. With `scanline`=12 or `cursor_blink`=0 → always 0.
- **Restart/reset:** `line_start` re-pulsed at `col`=2, phase 4 with `cpu_req` pending → `col` restarts at 0 and no ack is given. `reset` mid-line → all outputs 0 immediately, with no `load`.
